// File: rtl/ps2_line_buffer.sv
// PS/2 set-2 scan-code line buffer: decodes make/break/extended bytes,
// tracks shift, and assembles a small character line for a consumer.
//
// Ports:
//   clk, reset        - clock; synchronous active-high reset
//   key_valid         - one-cycle strobe qualifying key_code
//   key_code[7:0]     - PS/2 set-2 byte
//   line_out[8*DEPTH] - characters, newest in [7:0], unused slots 0x00
//   count[CW]         - number of valid characters
//   line_valid        - committed line waiting for the consumer
//   line_ready        - consumer accepts the line while line_valid is high
//   overflow          - sticky: a character was pushed out of a full line
module ps2_line_buffer #(
  parameter int DEPTH = 4,
  parameter bit UPPER = 1'b1,
  parameter int CW    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [7:0]         key_code,
  output logic [8*DEPTH-1:0] line_out,
  output logic [CW-1:0]      count,
  output logic               line_valid,
  input  logic               line_ready,
  output logic               overflow
);

  localparam int LW = 8 * DEPTH;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } state_t;

  state_t state_q, state_d;
  logic   shift_q, shift_d;
  logic   make;
  logic   is_shift;
  logic [8:0] mapped;

  logic [LW-1:0] line_q;
  logic [CW-1:0] count_q;
  logic          valid_q;
  logic          ovf_q;

  // Returns {hit, ascii}; letters honour the case flag, others do not.
  function automatic logic [8:0] map_key(
    input logic [7:0] k,
    input logic       up
  );
    logic [4:0] idx;
    logic       let_hit;
    logic [7:0] base;
    logic [8:0] r;
    idx     = '0;
    let_hit = 1'b1;
    r       = '0;
    case (k)
      8'h1C: idx = 5'd0;
      8'h32: idx = 5'd1;
      8'h21: idx = 5'd2;
      8'h23: idx = 5'd3;
      8'h24: idx = 5'd4;
      8'h2B: idx = 5'd5;
      8'h34: idx = 5'd6;
      8'h33: idx = 5'd7;
      8'h43: idx = 5'd8;
      8'h3B: idx = 5'd9;
      8'h42: idx = 5'd10;
      8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;
      8'h31: idx = 5'd13;
      8'h44: idx = 5'd14;
      8'h4D: idx = 5'd15;
      8'h15: idx = 5'd16;
      8'h2D: idx = 5'd17;
      8'h1B: idx = 5'd18;
      8'h2C: idx = 5'd19;
      8'h3C: idx = 5'd20;
      8'h2A: idx = 5'd21;
      8'h1D: idx = 5'd22;
      8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;
      8'h1A: idx = 5'd25;
      default: let_hit = 1'b0;
    endcase
    base = up ? 8'h41 : 8'h61;
    if (let_hit) begin
      r = {1'b1, base + 8'(idx)};
    end else begin
      case (k)
        8'h45: r = {1'b1, 8'h30};
        8'h16: r = {1'b1, 8'h31};
        8'h1E: r = {1'b1, 8'h32};
        8'h26: r = {1'b1, 8'h33};
        8'h25: r = {1'b1, 8'h34};
        8'h2E: r = {1'b1, 8'h35};
        8'h36: r = {1'b1, 8'h36};
        8'h3D: r = {1'b1, 8'h37};
        8'h3E: r = {1'b1, 8'h38};
        8'h46: r = {1'b1, 8'h39};
        8'h29: r = {1'b1, 8'h20};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  assign is_shift = (key_code == 8'h12) || (key_code == 8'h59);
  assign mapped   = map_key(key_code, UPPER ^ shift_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    make    = 1'b0;
    if (key_valid) begin
      unique case (state_q)
        IDLE: begin
          if (key_code == 8'hF0) begin
            state_d = BRK;
          end else if (key_code == 8'hE0) begin
            state_d = EXT;
          end else if (is_shift) begin
            shift_d = 1'b1;
          end else begin
            make = 1'b1;
          end
        end
        BRK: begin
          state_d = IDLE;
          if (is_shift) shift_d = 1'b0;
        end
        EXT: state_d = (key_code == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A committed line is frozen until accepted; acceptance beats any key.
  always_ff @(posedge clk) begin
    if (reset || (valid_q && line_ready)) begin
      line_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (make && !valid_q) begin
      if (mapped[8]) begin
        line_q <= (line_q << 8) | LW'(mapped[7:0]);
        if (count_q == FULL) ovf_q <= 1'b1;
        else count_q <= count_q + 1'b1;
      end else if (key_code == 8'h66) begin
        if (count_q != '0) begin
          line_q  <= line_q >> 8;
          count_q <= count_q - 1'b1;
        end
      end else if (key_code == 8'h5A) begin
        if (count_q != '0) valid_q <= 1'b1;
      end
    end
  end

  assign line_out   = line_q;
  assign count      = count_q;
  assign line_valid = valid_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_line_buffer.sv
// Directed self-checking bench for ps2_line_buffer (DEPTH=4, UPPER=1).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_ps2_line_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [31:0] line_out;
  logic [4:0]  count;
  logic        line_valid;
  logic        line_ready;
  logic        overflow;

  int n_assert = 0;
  int n_fail   = 0;

  ps2_line_buffer #(.DEPTH(4), .UPPER(1'b1), .CW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .line_out   (line_out),
    .count      (count),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] l,
                         input int c, input logic v, input logic o);
    chk({tag, ".line"}, line_out, l);
    chk({tag, ".count"}, {27'd0, count}, c);
    chk({tag, ".valid"}, {31'd0, line_valid}, {31'd0, v});
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, o});
  endtask

  task automatic send(input logic [7:0] b);
    key_valid = 1'b1;
    key_code  = b;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    key_valid  = 1'b0;
    key_code   = 8'h00;
    line_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_all("reset", 32'h0, 0, 1'b0, 1'b0);

    // basic append, one-cycle latency
    send(8'h1C);
    chk_all("a1", 32'h00000041, 1, 1'b0, 1'b0);
    send(8'h32);
    send(8'h21);
    chk_all("abc", 32'h00414243, 3, 1'b0, 1'b0);

    // reset clears a non-empty line
    do_reset();
    chk_all("rst_mid", 32'h0, 0, 1'b0, 1'b0);

    // shift held inverts case; break codes never appended
    send(8'h12);
    send(8'h1C);
    chk_all("shift_a", 32'h00000061, 1, 1'b0, 1'b0);
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12);
    send(8'h1C);
    chk_all("unshift", 32'h00006141, 2, 1'b0, 1'b0);

    // digits, space, shifted digit, unmapped make
    do_reset();
    send(8'h45);
    send(8'h29);
    send(8'h59);
    send(8'h16);
    send(8'h76);
    chk_all("digits", 32'h00302031, 3, 1'b0, 1'b0);
    send(8'hF0); send(8'h59);

    // overflow at full line
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    chk_all("full", 32'h41424344, 4, 1'b0, 1'b0);
    send(8'h24);
    chk_all("ovf", 32'h42434445, 4, 1'b0, 1'b1);
    send(8'h66);
    chk_all("ovf_bs", 32'h00424344, 3, 1'b0, 1'b1);

    // commit, hold, accept
    do_reset();
    send(8'h1C); send(8'h32); send(8'h66);
    chk_all("bs", 32'h00000041, 1, 1'b0, 1'b0);
    send(8'h5A);
    chk_all("enter", 32'h00000041, 1, 1'b1, 1'b0);
    send(8'h1C);
    send(8'h66);
    @(negedge clk);
    chk_all("hold", 32'h00000041, 1, 1'b1, 1'b0);
    line_ready = 1'b1;
    @(negedge clk);
    line_ready = 1'b0;
    chk_all("accept", 32'h0, 0, 1'b0, 1'b0);

    // accept and key in the same cycle: key only moves shift state
    send(8'h1C); send(8'h5A);
    chk_all("enter2", 32'h00000041, 1, 1'b1, 1'b0);
    line_ready = 1'b1;
    send(8'h12);
    line_ready = 1'b0;
    chk_all("acc_key", 32'h0, 0, 1'b0, 1'b0);
    send(8'h1C);
    chk_all("acc_shift", 32'h00000061, 1, 1'b0, 1'b0);
    send(8'hF0); send(8'h12);

    // reset while committed
    send(8'h5A);
    chk({"rv", ".pre"}, {31'd0, line_valid}, 32'd1);
    do_reset();
    chk_all("rst_valid", 32'h0, 0, 1'b0, 1'b0);

    // extended / break sequences ignored; empty backspace/enter
    send(8'h1C);
    send(8'hE0); send(8'h66);
    chk_all("ext", 32'h00000041, 1, 1'b0, 1'b0);
    send(8'hF0); send(8'h45);
    chk_all("brk", 32'h00000041, 1, 1'b0, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h1C);
    chk_all("extbrk", 32'h00000041, 1, 1'b0, 1'b0);
    send(8'h66);
    send(8'h66);
    send(8'h5A);
    chk_all("empty", 32'h0, 0, 1'b0, 1'b0);

    // reset mid-sequence returns FSM to idle
    send(8'hF0);
    do_reset();
    send(8'h1C);
    chk_all("rst_fsm", 32'h00000041, 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
